ahb2ocp_ram_2p: RTL and testbench

- Parametrised two-port (1 write, 1 read) synchronous RAM for the AHB-to-OCP bridge data/response buffers.
- Successor to the single-port bit-enable buffer RAM. Adds:
  - independent read and write addresses
  - byte-lane write enables
  - selectable read latency with rvalid
  - write-to-read bypass
  - correct range checking with error outputs
- Sits between the bridge request FSM and the OCP response path.

---
 rtl/ahb2ocp_ram_pkg.sv | 39 +++
 rtl/ahb2ocp_ram_rd_pipe.sv | 71 +++++++
 rtl/ahb2ocp_ram_2p.sv | 121 ++++++++++++
 tb/tb_ahb2ocp_ram_2p.sv | 230 +++++++++++++++++++++++
 4 files changed

// File: rtl/ahb2ocp_ram_pkg.sv
// Shared constants and lane helpers for the AHB-to-OCP two-port buffer RAM.
// Helpers work on a fixed maximum width; callers size-cast in and out.
package ahb2ocp_ram_pkg;

  localparam int LANE_SIZE_DEF = 8;
  localparam int RD_LAT_1      = 1;
  localparam int RD_LAT_2      = 2;

  localparam int MAX_W  = 256;
  localparam int MAX_IW = $clog2(MAX_W);

  // Bit b comes from new_w when the lane holding b is enabled in be.
  function automatic logic [MAX_W-1:0] lane_merge(
    input logic [MAX_W-1:0] old_w,
    input logic [MAX_W-1:0] new_w,
    input logic [MAX_W-1:0] be,
    input int               lane_size
  );
    logic [MAX_W-1:0] r;
    for (int b = 0; b < MAX_W; b++) begin
      r[MAX_IW'(b)] = be[MAX_IW'(b / lane_size)] ? new_w[MAX_IW'(b)] : old_w[MAX_IW'(b)];
    end
    return r;
  endfunction

  // Even parity per lane: result bit i is the XOR of lane i.
  function automatic logic [MAX_W-1:0] lane_parity(
    input logic [MAX_W-1:0] d,
    input int               lane_size
  );
    logic [MAX_W-1:0] p;
    p = '0;
    for (int b = 0; b < MAX_W; b++) begin
      p[MAX_IW'(b / lane_size)] = p[MAX_IW'(b / lane_size)] ^ d[MAX_IW'(b)];
    end
    return p;
  endfunction

endpackage

// File: rtl/ahb2ocp_ram_rd_pipe.sv
// Read-response pipeline, one or two register stages deep.
// Error flags are gated by valid so they only ever pulse alongside it.
module ahb2ocp_ram_rd_pipe
  import ahb2ocp_ram_pkg::*;
#(
  parameter int DATA_SIZE  = 32,
  parameter int RD_LATENCY = RD_LAT_1
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 vld_i,
  input  logic [DATA_SIZE-1:0] data_i,
  input  logic                 rd_err_i,
  input  logic                 par_err_i,
  output logic                 vld_o,
  output logic [DATA_SIZE-1:0] data_o,
  output logic                 rd_err_o,
  output logic                 par_err_o
);

  logic                 s1_vld_q;
  logic                 s1_rd_err_q;
  logic                 s1_par_err_q;
  logic [DATA_SIZE-1:0] s1_data_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_vld_q     <= 1'b0;
      s1_rd_err_q  <= 1'b0;
      s1_par_err_q <= 1'b0;
      s1_data_q    <= '0;
    end else begin
      s1_vld_q     <= vld_i;
      s1_rd_err_q  <= vld_i & rd_err_i;
      s1_par_err_q <= vld_i & par_err_i;
      if (vld_i) s1_data_q <= data_i;
    end
  end

  if (RD_LATENCY == RD_LAT_2) begin : g_lat2
    logic                 s2_vld_q;
    logic                 s2_rd_err_q;
    logic                 s2_par_err_q;
    logic [DATA_SIZE-1:0] s2_data_q;

    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        s2_vld_q     <= 1'b0;
        s2_rd_err_q  <= 1'b0;
        s2_par_err_q <= 1'b0;
        s2_data_q    <= '0;
      end else begin
        s2_vld_q     <= s1_vld_q;
        s2_rd_err_q  <= s1_rd_err_q;
        s2_par_err_q <= s1_par_err_q;
        if (s1_vld_q) s2_data_q <= s1_data_q;
      end
    end

    assign vld_o     = s2_vld_q;
    assign data_o    = s2_data_q;
    assign rd_err_o  = s2_rd_err_q;
    assign par_err_o = s2_par_err_q;
  end else begin : g_lat1
    assign vld_o     = s1_vld_q;
    assign data_o    = s1_data_q;
    assign rd_err_o  = s1_rd_err_q;
    assign par_err_o = s1_par_err_q;
  end

endmodule

// File: rtl/ahb2ocp_ram_2p.sv
// Two-port (1W/1R) byte-lane buffer RAM with range checks and optional bypass.
// Define AHB2OCP_RAM_PARITY_EN to add per-lane even parity with error injection.
module ahb2ocp_ram_2p
  import ahb2ocp_ram_pkg::*;
#(
  parameter int WORDS      = 16,
  parameter int DATA_SIZE  = 32,
  parameter int LANE_SIZE  = LANE_SIZE_DEF,
  parameter int ADDR_SIZE  = 4,
  parameter int RD_LATENCY = RD_LAT_1,
  parameter int BYPASS     = 1
) (
  input  logic                           clk,
  input  logic                           rst_n,
  input  logic                           cs,
  input  logic                           wr_e,
  input  logic [ADDR_SIZE-1:0]           wr_addr,
  input  logic [DATA_SIZE-1:0]           wdata,
  input  logic [DATA_SIZE/LANE_SIZE-1:0] be,
  input  logic                           rd_e,
  input  logic [ADDR_SIZE-1:0]           rd_addr,
  output logic [DATA_SIZE-1:0]           rdata,
  output logic                           rvalid,
  output logic                           rd_err,
  output logic                           wr_err,
  input  logic                           err_clr,
  input  logic                           par_inj,
  output logic                           par_err
);

  localparam int                 LANES     = DATA_SIZE / LANE_SIZE;
  localparam logic [ADDR_SIZE:0] WORDS_LIM = (ADDR_SIZE+1)'(WORDS);

  logic                 wr_acc, wr_in_range, wr_ok, wr_bad;
  logic                 rd_acc, rd_in_range, rd_ok, rd_hit;
  logic [DATA_SIZE-1:0] mem_q [WORDS];
  logic [DATA_SIZE-1:0] rd_old, rd_merged, rd_data_d;
  logic                 par_err_d;
  logic                 wr_err_q, wr_err_d;

  assign wr_acc      = cs & wr_e;
  assign wr_in_range = {1'b0, wr_addr} < WORDS_LIM;
  assign wr_ok       = wr_acc & wr_in_range;
  assign wr_bad      = wr_acc & ~wr_in_range;

  assign rd_acc      = cs & rd_e;
  assign rd_in_range = {1'b0, rd_addr} < WORDS_LIM;
  assign rd_ok       = rd_acc & rd_in_range;
  assign rd_hit      = wr_ok & rd_ok & (wr_addr == rd_addr) & (BYPASS != 0);

  always_ff @(posedge clk) begin
    if (wr_ok) begin
      for (int i = 0; i < LANES; i++) begin
        if (be[i]) mem_q[wr_addr][i*LANE_SIZE +: LANE_SIZE] <= wdata[i*LANE_SIZE +: LANE_SIZE];
      end
    end
  end

  // Out-of-range reads never touch the array and return zeros.
  always_comb begin
    rd_old = '0;
    if (rd_ok) rd_old = mem_q[rd_addr];
    rd_merged = DATA_SIZE'(lane_merge(MAX_W'(rd_old), MAX_W'(wdata), MAX_W'(be), LANE_SIZE));
    rd_data_d = rd_hit ? rd_merged : rd_old;
  end

`ifdef AHB2OCP_RAM_PARITY_EN
  logic [LANES-1:0] par_mem_q [WORDS];
  logic [LANES-1:0] fresh_par, wr_par, stored_par, calc_par;

  // Bypassed lanes compare against fresh parity, so injection only shows on a later read.
  always_comb begin
    fresh_par  = LANES'(lane_parity(MAX_W'(wdata), LANE_SIZE));
    wr_par     = fresh_par ^ {LANES{par_inj}};
    stored_par = '0;
    if (rd_ok) stored_par = par_mem_q[rd_addr];
    if (rd_hit) stored_par = (stored_par & ~be) | (fresh_par & be);
    calc_par   = LANES'(lane_parity(MAX_W'(rd_data_d), LANE_SIZE));
    par_err_d  = rd_ok & (|(calc_par ^ stored_par));
  end

  always_ff @(posedge clk) begin
    if (wr_ok) begin
      for (int i = 0; i < LANES; i++) begin
        if (be[i]) par_mem_q[wr_addr][i] <= wr_par[i];
      end
    end
  end
`else
  logic unused_par_inj;
  assign unused_par_inj = par_inj;
  assign par_err_d      = 1'b0;
`endif

  // A new out-of-range write outranks a simultaneous clear.
  assign wr_err_d = wr_bad | (wr_err_q & ~err_clr);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) wr_err_q <= 1'b0;
    else        wr_err_q <= wr_err_d;
  end

  assign wr_err = wr_err_q;

  ahb2ocp_ram_rd_pipe #(
    .DATA_SIZE  (DATA_SIZE),
    .RD_LATENCY (RD_LATENCY)
  ) u_rd_pipe (
    .clk       (clk),
    .rst_n     (rst_n),
    .vld_i     (rd_acc),
    .data_i    (rd_data_d),
    .rd_err_i  (rd_acc & ~rd_in_range),
    .par_err_i (par_err_d),
    .vld_o     (rvalid),
    .data_o    (rdata),
    .rd_err_o  (rd_err),
    .par_err_o (par_err)
  );

endmodule

// File: tb/tb_ahb2ocp_ram_2p.sv
// Scoreboard bench for ahb2ocp_ram_2p: two configurations driven by shared stimulus.
// Instance 0: WORDS=12, latency 1, bypass on. Instance 1: WORDS=16, latency 2, bypass off.
module tb_ahb2ocp_ram_2p;

  localparam int NDUT = 2;
  localparam int W0 = 12, L0 = 1, B0 = 1;
  localparam int W1 = 16, L1 = 2, B1 = 0;
`ifdef AHB2OCP_RAM_PARITY_EN
  localparam bit PAR_ON = 1'b1;
`else
  localparam bit PAR_ON = 1'b0;
`endif

  typedef struct {
    logic [31:0] data;
    logic        rd_err;
    logic        par_err;
    int          due;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst_n = 1'b1;
  logic        cs = 1'b0, wr_e = 1'b0, rd_e = 1'b0, err_clr = 1'b0, par_inj = 1'b0;
  logic [3:0]  wr_addr = '0, rd_addr = '0, be = '0;
  logic [31:0] wdata = '0;

  logic [31:0] rdata_w   [NDUT];
  logic        rvalid_w  [NDUT];
  logic        rd_err_w  [NDUT];
  logic        wr_err_w  [NDUT];
  logic        par_err_w [NDUT];

  logic [31:0] mdl_mem    [NDUT][16];
  logic [3:0]  mdl_bad    [NDUT][16];
  logic        mdl_wr_err [NDUT];
  logic [31:0] last_data  [NDUT];
  exp_t        sb_q       [NDUT][$];

  int checks = 0;
  int errors = 0;
  int cyc = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  ahb2ocp_ram_2p #(
    .WORDS(W0), .DATA_SIZE(32), .LANE_SIZE(8), .ADDR_SIZE(4), .RD_LATENCY(L0), .BYPASS(B0)
  ) dut_a (
    .clk(clk), .rst_n(rst_n), .cs(cs), .wr_e(wr_e), .wr_addr(wr_addr), .wdata(wdata), .be(be),
    .rd_e(rd_e), .rd_addr(rd_addr), .rdata(rdata_w[0]), .rvalid(rvalid_w[0]), .rd_err(rd_err_w[0]),
    .wr_err(wr_err_w[0]), .err_clr(err_clr), .par_inj(par_inj), .par_err(par_err_w[0])
  );

  ahb2ocp_ram_2p #(
    .WORDS(W1), .DATA_SIZE(32), .LANE_SIZE(8), .ADDR_SIZE(4), .RD_LATENCY(L1), .BYPASS(B1)
  ) dut_b (
    .clk(clk), .rst_n(rst_n), .cs(cs), .wr_e(wr_e), .wr_addr(wr_addr), .wdata(wdata), .be(be),
    .rd_e(rd_e), .rd_addr(rd_addr), .rdata(rdata_w[1]), .rvalid(rvalid_w[1]), .rd_err(rd_err_w[1]),
    .wr_err(wr_err_w[1]), .err_clr(err_clr), .par_inj(par_inj), .par_err(par_err_w[1])
  );

  task automatic chk(input string name, input int k, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s dut%0d cyc %0d got %h want %h", name, k, cyc, act, exp);
    end
  endtask

  // Reference behaviour for the current input cycle: reads see pre-write content,
  // except that a bypassing instance sees written lanes of the same word.
  task automatic model_step(input int k);
    int          words;
    exp_t        e;
    logic [31:0] d;
    logic [3:0]  bad;
    logic        wr_ok;
    words = (k == 0) ? W0 : W1;
    wr_ok = cs && wr_e && (int'(wr_addr) < words);
    if (cs && rd_e) begin
      e.due = cyc + ((k == 0) ? L0 : L1);
      if (int'(rd_addr) >= words) begin
        e.data = '0; e.rd_err = 1'b1; e.par_err = 1'b0;
      end else begin
        d   = mdl_mem[k][rd_addr];
        bad = mdl_bad[k][rd_addr];
        if ((((k == 0) ? B0 : B1) != 0) && wr_ok && (wr_addr == rd_addr)) begin
          for (int l = 0; l < 4; l++) begin
            if (be[l]) begin
              d[l*8 +: 8] = wdata[l*8 +: 8];
              bad[l] = 1'b0;
            end
          end
        end
        e.data = d; e.rd_err = 1'b0; e.par_err = PAR_ON && (bad != 4'b0);
      end
      sb_q[k].push_back(e);
    end
    if (wr_ok) begin
      for (int l = 0; l < 4; l++) begin
        if (be[l]) begin
          mdl_mem[k][wr_addr][l*8 +: 8] = wdata[l*8 +: 8];
          mdl_bad[k][wr_addr][l] = par_inj;
        end
      end
    end
    if (cs && wr_e && !wr_ok) mdl_wr_err[k] = 1'b1;
    else if (err_clr)         mdl_wr_err[k] = 1'b0;
  endtask

  task automatic drive(input logic c, input logic we, input logic [3:0] wa, input logic [31:0] wd,
                       input logic [3:0] b, input logic re, input logic [3:0] ra,
                       input logic pi, input logic ec);
    @(negedge clk);
    cs = c; wr_e = we; wr_addr = wa; wdata = wd; be = b;
    rd_e = re; rd_addr = ra; par_inj = pi; err_clr = ec;
    for (int k = 0; k < NDUT; k++) model_step(k);
  endtask

  task automatic idle(input int n);
    repeat (n) drive(1'b0, 1'b0, 4'd0, 32'd0, 4'd0, 1'b0, 4'd0, 1'b0, 1'b0);
  endtask

  task automatic rd(input logic [3:0] a);
    drive(1'b1, 1'b0, 4'd0, 32'd0, 4'd0, 1'b1, a, 1'b0, 1'b0);
  endtask

  task automatic do_reset(input int n);
    @(negedge clk);
    rst_n = 1'b0;
    cs = 1'b0; wr_e = 1'b0; rd_e = 1'b0; err_clr = 1'b0; par_inj = 1'b0;
    for (int k = 0; k < NDUT; k++) begin
      sb_q[k].delete();
      mdl_wr_err[k] = 1'b0;
      last_data[k]  = '0;
    end
    repeat (n) @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic monitor(input int k);
    exp_t e;
    if (rvalid_w[k] === 1'b1) begin
      if (sb_q[k].size() == 0) begin
        checks++; errors++;
        $display("FAIL spurious_rvalid dut%0d cyc %0d got rvalid=1 want 0", k, cyc);
      end else begin
        e = sb_q[k].pop_front();
        chk("rvalid_cycle", k, cyc, e.due);
        chk("rdata", k, rdata_w[k], e.data);
        chk("rd_err", k, 32'(rd_err_w[k]), 32'(e.rd_err));
        chk("par_err", k, 32'(par_err_w[k]), 32'(e.par_err));
        last_data[k] = e.data;
      end
    end else begin
      chk("rvalid_idle", k, 32'(rvalid_w[k]), 32'd0);
      if (sb_q[k].size() != 0 && sb_q[k][0].due <= cyc) begin
        checks++; errors++;
        $display("FAIL missing_rvalid dut%0d cyc %0d got rvalid=0 want 1", k, cyc);
        e = sb_q[k].pop_front();
      end
      chk("rdata_hold", k, rdata_w[k], last_data[k]);
      chk("rd_err_idle", k, 32'(rd_err_w[k]), 32'd0);
      chk("par_err_idle", k, 32'(par_err_w[k]), 32'd0);
    end
    chk("wr_err", k, 32'(wr_err_w[k]), 32'(mdl_wr_err[k]));
  endtask

  for (genvar gi = 0; gi < NDUT; gi++) begin : g_mon
    always @(posedge clk) begin
      #1;
      monitor(gi);
    end
  end

  initial begin
    logic [3:0] wa, ra;
    for (int k = 0; k < NDUT; k++) begin
      mdl_wr_err[k] = 1'b0;
      last_data[k]  = '0;
    end
    #1 rst_n = 1'b0;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    idle(2);

    for (int a = 0; a < 16; a++) drive(1'b1, 1'b1, 4'(a), 32'd0, 4'hF, 1'b0, 4'd0, 1'b0, 1'b0);
    drive(1'b0, 1'b0, 4'd0, 32'd0, 4'd0, 1'b0, 4'd0, 1'b0, 1'b1);

    drive(1'b1, 1'b1, 4'd3, 32'hDEADBEEF, 4'hF, 1'b0, 4'd0, 1'b0, 1'b0);
    rd(4'd3);
    drive(1'b1, 1'b1, 4'd3, 32'h11223344, 4'b0101, 1'b0, 4'd0, 1'b0, 1'b0);
    rd(4'd3);
    drive(1'b1, 1'b1, 4'd5, 32'hA5A5A5A5, 4'hF, 1'b1, 4'd5, 1'b0, 1'b0);
    rd(4'd5);

    drive(1'b1, 1'b1, 4'd12, 32'hCAFEF00D, 4'hF, 1'b0, 4'd0, 1'b0, 1'b0);
    for (int a = 0; a < 16; a++) rd(4'(a));
    drive(1'b1, 1'b1, 4'd13, 32'h0BADC0DE, 4'hF, 1'b0, 4'd0, 1'b0, 1'b1);
    drive(1'b0, 1'b0, 4'd0, 32'd0, 4'd0, 1'b0, 4'd0, 1'b0, 1'b1);
    drive(1'b0, 1'b1, 4'd14, 32'h12345678, 4'hF, 1'b1, 4'd15, 1'b0, 1'b0);
    idle(1);

    rd(4'd0); rd(4'd1); rd(4'd2);
    idle(4);
    rd(4'd0); rd(4'd1);
    do_reset(2);
    idle(3);

    drive(1'b1, 1'b1, 4'd7, 32'h00005A00, 4'b0010, 1'b0, 4'd0, 1'b1, 1'b0);
    rd(4'd7);
    drive(1'b1, 1'b1, 4'd7, 32'h76543210, 4'hF, 1'b0, 4'd0, 1'b0, 1'b0);
    rd(4'd7);
    idle(3);

    for (int n = 0; n < 400; n++) begin
      wa = 4'($urandom_range(0, 15));
      ra = ($urandom_range(0, 3) == 0) ? wa : 4'($urandom_range(0, 15));
      drive(1'($urandom_range(0, 9) != 0), 1'($urandom_range(0, 1)), wa, $urandom,
            4'($urandom_range(0, 15)), 1'($urandom_range(0, 1)), ra,
            1'($urandom_range(0, 7) == 0), 1'($urandom_range(0, 15) == 0));
    end
    idle(6);

    for (int k = 0; k < NDUT; k++) chk("drain", k, 32'(sb_q[k].size()), 32'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
